stdout_tx: RTL

STDOUT_TX -- requirements
Module: stdout_tx

---
 rtl/stdout_tx_pkg.sv | 27 ++
 rtl/stdout_tx_byte_fifo.sv | 58 +++++
 rtl/stdout_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/stdout_tx_pkg.sv
// Shared core package: memory sizing, load/store width modes and the
// stdout transmitter state encoding.
`default_nettype none

package stdout_tx_pkg;

    localparam int RAM_SIZE_LOG = 6;
    localparam int RAM_SIZE     = 1 << RAM_SIZE_LOG;

    typedef enum logic [2:0] {
        LDST_B  = 3'd0,
        LDST_H  = 3'd1,
        LDST_W  = 3'd2,
        LDST_BU = 3'd3,
        LDST_HU = 3'd4
    } ldst_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/stdout_tx_byte_fifo.sv
// byte_fifo: power-of-two byte FIFO with a combinational head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
`default_nettype none

module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    // On a simultaneous push/pop while full the head is read before the slot is rewritten.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stdout_tx.sv
// stdout_tx: snoops core stores to the stdout word and serialises the low byte
// as UART 8N1 through a small FIFO.
`default_nettype none

module stdout_tx
    import stdout_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [31:0] wa,
    input  logic [31:0] wd,
    input  ldst_mode_t  wm,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic [7:0]  drop_cnt
);

    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
            $error("stdout_tx: CLKS_PER_BIT out of range");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("stdout_tx: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    tx_state_t   state;
    logic [15:0] baud;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;

    logic        stdout_hit;
    logic        push;
    logic        pop;
    logic        baud_end;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        unused_bits;

    // Only the word index is decoded, so the stdout word aliases across the address space.
    assign stdout_hit  = (wa[RAM_SIZE_LOG+1:2] == RAM_SIZE_LOG'(RAM_SIZE - 1));
    assign push        = we && stdout_hit;
    assign baud_end    = (baud == 16'(CLKS_PER_BIT - 1));
    assign pop         = !fifo_empty && ((state == IDLE) || (state == STOP && baud_end));
    assign unused_bits = ^{wm, wa[31:RAM_SIZE_LOG+2], wa[1:0], wd[31:8]};

    assign busy = !fifo_empty || (state != IDLE);
    assign full = fifo_full;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (wd[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // tx is driven from the state before each edge, so the line lags the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (!fifo_empty) begin
                        shreg <= fifo_dout;
                        state <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_end) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                DATA: begin
                    tx <= shreg[bit_cnt];
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud <= '0;
                        if (!fifo_empty) begin
                            shreg <= fifo_dout;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    baud  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (push && fifo_full && !pop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire
